mm_bus_interconnect: RTL and testbench



---
 rtl/mm_bus_interconnect.sv | 167 ++++++++++++++++
 tb/tb_mm_bus_interconnect.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bus_interconnect.sv
// Memory-mapped interconnect between the picorv32 native port and NUM_SLAVES peripherals.
// Table-driven address decode, registered one-hot select, unmapped/timeout bus errors with sticky capture.
module mm_bus_interconnect #(
  parameter int                       NUM_SLAVES     = 6,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'h0}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERROR_DATA     = 32'hdead_beef
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      slave_sel,
  input  logic [NUM_SLAVES-1:0]      slave_ready,
  input  logic [NUM_SLAVES*32-1:0]   slave_data,
  input  logic                       err_clear,
  output logic                       err_irq,
  output logic                       err_valid,
  output logic [1:0]                 err_cause,
  output logic [31:0]                err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_SLAVES-1:0]  sel_q, sel_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [31:0]            req_addr_q, req_addr_d;
  logic [1:0]             cause_q, cause_d;
  logic                   err_valid_q, err_valid_d;
  logic [1:0]             err_cause_q, err_cause_d;
  logic [31:0]            err_addr_q, err_addr_d;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   sel_ready;
  logic [31:0]            sel_data;
  logic                   unused_wstrb;

  // The bus carries no write path of its own; strobes go straight to the slaves.
  assign unused_wstrb = ^mem_wstrb;

  // Scan from the top so the lowest matching slave is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ready = slave_ready[idx_q];
  assign sel_data  = slave_data[32*idx_q +: 32];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sel_q       <= '0;
      timer_q     <= '0;
      req_addr_q  <= '0;
      cause_q     <= '0;
      err_valid_q <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      req_addr_q  <= req_addr_d;
      cause_q     <= cause_d;
      err_valid_q <= err_valid_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_valid) state_d = hit ? ACTIVE : ERROR;
      ACTIVE: begin
        if (!mem_valid || sel_ready) state_d = IDLE;
        else if (timer_q == TMR_LAST) state_d = ERROR;
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    timer_d     = timer_q;
    req_addr_d  = req_addr_q;
    cause_d     = cause_q;
    err_valid_d = err_valid_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          req_addr_d = mem_addr;
          idx_d      = hit_idx;
          timer_d    = '0;
          cause_d    = CAUSE_UNMAPPED;
        end
      end
      ACTIVE: begin
        if (mem_valid && !sel_ready) begin
          timer_d = timer_q + 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
    sel_d = (state_d == ACTIVE) ? (NUM_SLAVES'(1) << idx_d) : '0;
    // A capture in the error cycle overrides a simultaneous clear.
    if (state_q == ERROR && (!err_valid_q || err_clear)) begin
      err_valid_d = 1'b1;
      err_cause_d = cause_q;
      err_addr_d  = req_addr_q;
    end else if (err_clear) begin
      err_valid_d = 1'b0;
      err_cause_d = '0;
      err_addr_d  = '0;
    end
  end

  always_comb begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    err_irq   = 1'b0;
    case (state_q)
      ACTIVE: begin
        mem_ready = mem_valid & sel_ready;
        mem_rdata = sel_data;
      end
      ERROR: begin
        mem_ready = 1'b1;
        mem_rdata = ERROR_DATA;
        err_irq   = 1'b1;
      end
      default: ;
    endcase
  end

  assign slave_sel = sel_q;
  assign err_valid = err_valid_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mm_bus_interconnect.sv
// Randomised, self-checking bench for mm_bus_interconnect with a transaction-level reference model.
module tb_mm_bus_interconnect;

  localparam int NS = 6;
  localparam int T  = 8;
  // slave5 flash, slave4 uart, slave3 debug window (overlaps rom), slave2 gpio, slave1 sram, slave0 rom
  localparam logic [NS*32-1:0] BASE = {32'h0100_0000, 32'h0200_0000, 32'h0000_1000,
                                       32'h0300_0000, 32'h0002_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hff00_0000, 32'hffff_ff00, 32'hffff_f000,
                                       32'hffff_ff00, 32'hffff_0000, 32'hfffe_0000};

  logic              clk = 1'b0;
  logic              reset_n;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [NS-1:0]     slave_sel;
  logic [NS-1:0]     slave_ready;
  logic [NS*32-1:0]  slave_data;
  logic              err_clear;
  logic              err_irq;
  logic              err_valid;
  logic [1:0]        err_cause;
  logic [31:0]       err_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] base_a [NS];
  logic [31:0] mask_a [NS];
  bit          ev;
  logic [1:0]  ec;
  logic [31:0] ea;

  mm_bus_interconnect #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(T), .ERROR_DATA(32'hdead_beef)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .slave_sel(slave_sel), .slave_ready(slave_ready), .slave_data(slave_data),
    .err_clear(err_clear), .err_irq(err_irq), .err_valid(err_valid),
    .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_a[i]) == base_a[i]) return i;
    return -1;
  endfunction

  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int w,
                         input bit rogue, input bit clr, input bit keep);
    int idx, done;
    bit mapped, bad;
    logic [NS-1:0] exp_sel, s;
    logic [31:0] data [NS];
    logic [31:0] exp_rd;
    idx     = ref_decode(addr);
    mapped  = (idx >= 0);
    bad     = !mapped || (w >= T);
    done    = !mapped ? 1 : ((w >= T) ? 1 + T : 1 + w);
    exp_sel = mapped ? (NS'(1) << idx) : '0;
    for (int i = 0; i < NS; i++) begin
      data[i] = $urandom;
      slave_data[32*i +: 32] = data[i];
    end
    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = wstrb;
    for (int k = 1; k <= done; k++) begin
      @(posedge clk); #1;
      slave_ready = rogue ? ~exp_sel : '0;
      if (!bad && k >= 1 + w) slave_ready[idx] = 1'b1;
      err_clear = clr && bad && (k == done);
      @(negedge clk);
      s = (k == done && bad) ? '0 : exp_sel;
      checks++;
      if (slave_sel !== s) begin
        errors++; $display("FAIL txn_sel addr=%h cyc=%0d got=%b want=%b", addr, k, slave_sel, s);
      end
      checks++;
      if (mem_ready !== (k == done)) begin
        errors++; $display("FAIL txn_ready addr=%h cyc=%0d got=%b want=%b", addr, k, mem_ready, k == done);
      end
      checks++;
      if (err_irq !== (k == done && bad)) begin
        errors++; $display("FAIL txn_irq addr=%h cyc=%0d got=%b want=%b", addr, k, err_irq, k == done && bad);
      end
      if (k == done) begin
        exp_rd = bad ? 32'hdead_beef : data[idx];
        checks++;
        if (mem_rdata !== exp_rd) begin
          errors++; $display("FAIL txn_rdata addr=%h got=%h want=%h", addr, mem_rdata, exp_rd);
        end
      end
    end
    if (bad && (!ev || clr)) begin
      ev = 1'b1; ec = mapped ? 2'b10 : 2'b01; ea = addr;
    end
    @(posedge clk); #1;
    mem_valid = keep; slave_ready = '0; err_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (slave_sel !== '0 || mem_ready !== 1'b0 || err_irq !== 1'b0 || mem_rdata !== '0) begin
      errors++; $display("FAIL txn_idle addr=%h got sel=%b rdy=%b irq=%b rd=%h want 0", addr, slave_sel, mem_ready, err_irq, mem_rdata);
    end
    checks++;
    if (err_valid !== ev || err_cause !== ec || err_addr !== ea) begin
      errors++; $display("FAIL txn_errstate addr=%h got %b/%b/%h want %b/%b/%h", addr, err_valid, err_cause, err_addr, ev, ec, ea);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wstrb = '0;
    slave_ready = '0; slave_data = '0; err_clear = 1'b0;
    ev = 1'b0; ec = '0; ea = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (slave_sel !== '0 || mem_ready !== 1'b0 || mem_rdata !== '0 || err_irq !== 1'b0) begin
      errors++; $display("FAIL reset_bus got sel=%b rdy=%b rd=%h irq=%b want 0", slave_sel, mem_ready, mem_rdata, err_irq);
    end
    checks++;
    if (err_valid !== 1'b0 || err_cause !== 2'b00 || err_addr !== '0) begin
      errors++; $display("FAIL reset_err got %b/%b/%h want 0/00/0", err_valid, err_cause, err_addr);
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_err_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    ev = 1'b0; ec = '0; ea = '0;
    @(negedge clk);
    checks++;
    if (err_valid !== 1'b0 || err_cause !== 2'b00 || err_addr !== '0) begin
      errors++; $display("FAIL err_clear got %b/%b/%h want 0/00/0", err_valid, err_cause, err_addr);
    end
  endtask

  task automatic test_sticky();
    run_txn(32'h4000_0000, 4'h0, 0, 0, 0, 0);
    run_txn(32'h4000_0100, 4'hf, 0, 0, 0, 0);
    run_txn(32'h4000_0200, 4'h0, 0, 0, 1, 0);
  endtask

  task automatic test_abort();
    mem_valid = 1'b1; mem_addr = 32'h0002_0010; mem_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (slave_sel !== 6'b000010) begin
      errors++; $display("FAIL abort_sel got=%b want=000010", slave_sel);
    end
    @(posedge clk); #1 mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready got=%b want=0", mem_ready);
    end
    for (int k = 0; k < T + 2; k++) begin
      @(negedge clk);
      checks++;
      if (slave_sel !== '0 || err_irq !== 1'b0 || mem_ready !== 1'b0) begin
        errors++; $display("FAIL abort_idle cyc=%0d got sel=%b irq=%b rdy=%b want 0", k, slave_sel, err_irq, mem_ready);
      end
    end
    checks++;
    if (err_valid !== ev || err_addr !== ea) begin
      errors++; $display("FAIL abort_err got %b/%h want %b/%h", err_valid, err_addr, ev, ea);
    end
  endtask

  task automatic test_reset_mid();
    run_txn(32'h4000_0400, 4'h0, 0, 0, 0, 0);
    mem_valid = 1'b1; mem_addr = 32'h0300_0004; mem_wstrb = 4'hf;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1; mem_valid = 1'b0;
    ev = 1'b0; ec = '0; ea = '0;
    @(negedge clk);
    checks++;
    if (slave_sel !== '0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid got sel=%b rdy=%b want 0/0", slave_sel, mem_ready);
    end
    checks++;
    if (err_valid !== 1'b0 || err_addr !== '0) begin
      errors++; $display("FAIL reset_mid_err got %b/%h want 0/0", err_valid, err_addr);
    end
    run_txn(32'h0300_0008, 4'h0, 2, 0, 0, 0);
  endtask

  task automatic test_random();
    int r, n;
    logic [31:0] a;
    n = 30;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, NS);
      if (r == NS) a = 32'h4000_0000 + $urandom_range(0, 32'hffff);
      else         a = base_a[r] | ($urandom & ~mask_a[r]);
      run_txn(a, 4'($urandom), $urandom_range(0, 10), 1'($urandom), 1'($urandom),
              (i < n - 1) && 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      base_a[i] = BASE[32*i +: 32];
      mask_a[i] = MASK[32*i +: 32];
    end
    test_reset();
    run_txn(32'h0002_0004, 4'h0, 1, 0, 0, 0);
    run_txn(32'h0000_0100, 4'h0, 0, 0, 0, 0);
    run_txn(32'h4000_0000, 4'h0, 0, 0, 0, 0);
    run_txn(32'h0200_0000, 4'h0, 100, 0, 0, 0);
    test_err_clear();
    test_sticky();
    run_txn(32'h0000_1234, 4'h0, 3, 1, 0, 0);
    run_txn(32'h0002_0000, 4'hf, 0, 0, 0, 1);
    run_txn(32'h0100_0040, 4'h0, 7, 1, 0, 1);
    run_txn(32'h0200_0010, 4'h0, 2, 0, 0, 0);
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
